// File: rtl/nv_nvdla_cdma_wt_wrr_arb.sv
// ---------------------------------------------------------------------------
// nv_nvdla_cdma_wt_wrr_arb
//
// N-requester grant arbiter for the CDMA weight-fetch path. Selects one
// requester per cycle either by strict priority (lowest index wins) or by
// round-robin starting at a stored grant pointer. When the macro
// NVDLA_CDMA_WT_ARB_WRR_EN is defined, the round-robin is weighted: a
// requester sitting at the pointer may take up to cfg_weight[i] consecutive
// grants before the pointer moves on. Without the macro every weight is 1
// and the arbiter is a plain round-robin.
//
// Ports:
//   nvdla_core_clk  core clock
//   nvdla_core_rst  asynchronous active-high reset
//   req             request vector, bit i = requester i
//   gnt_busy        downstream busy, forces gnt to zero
//   cfg_mode        0 = strict priority, 1 = round-robin
//   cfg_weight      per-requester weight, field i at [i*WT_W +: WT_W]
//   gnt             one-hot-or-zero grant, combinational
//   gnt_id_d        registered index of the last fired winner
//   gnt_vld_d       registered pulse, high the cycle after a fire
// ---------------------------------------------------------------------------
module nv_nvdla_cdma_wt_wrr_arb #(
   parameter  int NUM_REQ = 4,
   parameter  int WT_W    = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                    nvdla_core_clk,
   input  logic                    nvdla_core_rst,
   input  logic [NUM_REQ-1:0]      req,
   input  logic                    gnt_busy,
   input  logic                    cfg_mode,
   input  logic [NUM_REQ*WT_W-1:0] cfg_weight,
   output logic [NUM_REQ-1:0]      gnt,
   output logic [ID_W-1:0]         gnt_id_d,
   output logic                    gnt_vld_d
);

   logic [ID_W-1:0] ptr;
   logic [WT_W-1:0] cnt;
   logic [ID_W-1:0] strict_id;
   logic [ID_W-1:0] rr_id;
   logic [ID_W-1:0] win_id;
   logic [ID_W-1:0] win_inc;
   logic            any_req;
   logic            fire;

   // Strict priority: scanning from the top down lets the lowest asserted
   // index be the last one written, so it wins.
   always_comb begin
      strict_id = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            strict_id = ID_W'(i);
         end
      end
   end

   // Round-robin search order is ptr, ptr+1, ... with wrap. Walking the
   // offsets from largest to smallest means the closest requester to ptr
   // is written last and wins. The wrap is a subtract rather than a modulo
   // so that non-power-of-2 NUM_REQ never produces an index >= NUM_REQ.
   always_comb begin
      int idx;
      idx   = 0;
      rr_id = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (req[idx[ID_W-1:0]]) begin
            rr_id = idx[ID_W-1:0];
         end
      end
   end

   // Grant selection. Reset and busy both squash the grant, which in turn
   // squashes the fire so no state moves during a stall or reset.
   always_comb begin
      any_req = |req;
      win_id  = cfg_mode ? rr_id : strict_id;
      win_inc = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
      gnt     = '0;
      if (any_req && !gnt_busy && !nvdla_core_rst) begin
         gnt = NUM_REQ'(1) << win_id;
      end
      fire    = |gnt;
   end

`ifdef NVDLA_CDMA_WT_ARB_WRR_EN
   logic [WT_W-1:0] wt;
   logic [WT_W:0]   cnt_inc;
   logic            burst_done;

   // Effective weight of the current winner; a programmed zero behaves as 1.
   always_comb begin
      wt = WT_W'(1);
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_id == ID_W'(i) && cfg_weight[i*WT_W +: WT_W] != '0) begin
            wt = cfg_weight[i*WT_W +: WT_W];
         end
      end
   end

   // The burst comparison is one bit wider than the weight so that the
   // largest weight value cannot wrap cnt+1 back to zero.
   assign cnt_inc    = {1'b0, cnt} + (WT_W+1)'(1);
   assign burst_done = cnt_inc >= {1'b0, wt};

   // Weighted pointer/credit update. Only round-robin fires touch the state;
   // a winner other than ptr starts a fresh burst of its own (or passes the
   // pointer on immediately if its weight is 1).
   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         ptr <= '0;
         cnt <= '0;
      end else if (fire && cfg_mode) begin
         if (win_id == ptr) begin
            if (burst_done) begin
               ptr <= win_inc;
               cnt <= '0;
            end else begin
               cnt <= cnt_inc[WT_W-1:0];
            end
         end else if (wt == WT_W'(1)) begin
            ptr <= win_inc;
            cnt <= '0;
         end else begin
            ptr <= win_id;
            cnt <= WT_W'(1);
         end
      end
   end
`else
   logic unused_cfg;

   // Without weighting there is no burst credit; the weight bus is kept on
   // the port list for drop-in compatibility but is not used.
   assign cnt        = '0;
   assign unused_cfg = ^{cfg_weight, cnt};

   // Plain round-robin: every round-robin fire hands the pointer to the
   // requester just above the winner.
   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         ptr <= '0;
      end else if (fire && cfg_mode) begin
         ptr <= win_inc;
      end
   end
`endif

   // Registered winner report for the request mux and perf counters. The
   // index holds between fires; the valid bit is a single-cycle pulse.
   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         gnt_id_d  <= '0;
         gnt_vld_d <= 1'b0;
      end else begin
         gnt_vld_d <= fire;
         if (fire) begin
            gnt_id_d <= win_id;
         end
      end
   end

endmodule

// File: tb/tb_nv_nvdla_cdma_wt_wrr_arb.sv
// ---------------------------------------------------------------------------
// tb_nv_nvdla_cdma_wt_wrr_arb
//
// Drives a 4-requester and a 3-requester arbiter from the same stimulus.
// A behavioural model predicts each cycle's grant and every fire; the
// predictions are queued, and a monitor on the falling edge pops and
// compares them against the DUT outputs. Honours NVDLA_CDMA_WT_ARB_WRR_EN
// the same way the design does.
// ---------------------------------------------------------------------------
module tb_nv_nvdla_cdma_wt_wrr_arb;

   typedef struct {
      int id;
      int due;
   } fire_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic        busy;
   logic        mode;
   logic [15:0] weight;

   logic [3:0]  gnt4;
   logic [1:0]  id4;
   logic        vld4;
   logic [2:0]  gnt3;
   logic [1:0]  id3;
   logic        vld3;

   int    gnt_q[2][$];
   fire_t fire_q[2][$];
   int    m_ptr[2];
   int    m_cnt[2];
   int    last_id[2];
   int    stim_cyc = 0;
   int    mon_cyc  = 0;
   int    checks   = 0;
   int    errors   = 0;

   nv_nvdla_cdma_wt_wrr_arb #(.NUM_REQ(4), .WT_W(4)) u_dut4 (
      .nvdla_core_clk (clk),
      .nvdla_core_rst (rst),
      .req            (req),
      .gnt_busy       (busy),
      .cfg_mode       (mode),
      .cfg_weight     (weight),
      .gnt            (gnt4),
      .gnt_id_d       (id4),
      .gnt_vld_d      (vld4)
   );

   nv_nvdla_cdma_wt_wrr_arb #(.NUM_REQ(3), .WT_W(4)) u_dut3 (
      .nvdla_core_clk (clk),
      .nvdla_core_rst (rst),
      .req            (req[2:0]),
      .gnt_busy       (busy),
      .cfg_mode       (mode),
      .cfg_weight     (weight[11:0]),
      .gnt            (gnt3),
      .gnt_id_d       (id3),
      .gnt_vld_d      (vld3)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   function automatic int nreq(int k);
      return (k == 0) ? 4 : 3;
   endfunction

   // Winner by the arbitration rules: lowest index in strict mode, first
   // requester found walking up from the pointer (with wrap) in RR mode.
   function automatic int modelWinner(int k, logic [3:0] rq, logic md);
      int n;
      int c;
      n = nreq(k);
      for (int j = 0; j < n; j++) begin
         c = md ? (m_ptr[k] + j) % n : j;
         if (rq[c[1:0]]) return c;
      end
      return -1;
   endfunction

   // Pointer/credit bookkeeping for one round-robin fire.
   function automatic void modelUpdate(int k, int w, logic [15:0] wts);
      int n;
      int wt;
      n = nreq(k);
`ifdef NVDLA_CDMA_WT_ARB_WRR_EN
      wt = int'((wts >> (4 * w)) & 16'hF);
      if (wt == 0) wt = 1;
`else
      wt = 1;
      if (wts == 16'hFFFF && n == 0) wt = 1;
`endif
      if (w == m_ptr[k]) begin
         if (m_cnt[k] + 1 >= wt) begin
            m_ptr[k] = (w + 1) % n;
            m_cnt[k] = 0;
         end else begin
            m_cnt[k] = m_cnt[k] + 1;
         end
      end else if (wt == 1) begin
         m_ptr[k] = (w + 1) % n;
         m_cnt[k] = 0;
      end else begin
         m_ptr[k] = w;
         m_cnt[k] = 1;
      end
   endfunction

   task automatic compare(input string name, input int k, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s inst%0d cyc %0d: got %0d expected %0d",
                  name, k, mon_cyc, act, exp);
      end
   endtask

   // One stimulus cycle: drive inputs just after the rising edge, predict
   // the grant for this cycle and, if it fires, the report for the next.
   task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic b,
                                input logic md, input logic [15:0] wts);
      int w;
      int eg;
      @(posedge clk);
      #1;
      rst    = r;
      req    = rq;
      busy   = b;
      mode   = md;
      weight = wts;
      stim_cyc++;
      for (int k = 0; k < 2; k++) begin
         if (r) begin
            m_ptr[k] = 0;
            m_cnt[k] = 0;
            fire_q[k].delete();
         end
         w  = modelWinner(k, rq, md);
         eg = 0;
         if (!r && !b && w >= 0) begin
            eg = 1 << w;
            fire_q[k].push_back('{id: w, due: stim_cyc + 1});
            if (md) modelUpdate(k, w, wts);
         end
         gnt_q[k].push_back(eg);
      end
   endtask

   task automatic checkOutput(input int k, input int act_gnt, input int act_vld, input int act_id);
      int eg;
      int ev;
      int eid;
      eg = gnt_q[k].pop_front();
      ev = 0;
      if (rst) last_id[k] = 0;
      eid = last_id[k];
      if (fire_q[k].size() > 0 && fire_q[k][0].due == mon_cyc) begin
         ev         = 1;
         eid        = fire_q[k][0].id;
         last_id[k] = eid;
         fire_q[k].delete(0);
      end
      compare("gnt", k, act_gnt, eg);
      compare("gnt_vld_d", k, act_vld, ev);
      compare("gnt_id_d", k, act_id, eid);
   endtask

   // Monitor: once per cycle on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (gnt_q[0].size() > 0 && gnt_q[1].size() > 0) begin
         mon_cyc++;
         checkOutput(0, int'(gnt4), int'(vld4), int'(id4));
         checkOutput(1, int'(gnt3), int'(vld3), int'(id3));
      end
   end

   // Directed scenarios followed by a randomized soak.
   initial begin
      logic        md_r;
      logic [15:0] wt_r;
      rst    = 1'b1;
      req    = '0;
      busy   = 1'b0;
      mode   = 1'b0;
      weight = 16'h1111;
      for (int k = 0; k < 2; k++) begin
         m_ptr[k]   = 0;
         m_cnt[k]   = 0;
         last_id[k] = 0;
      end

      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0, 16'h1111);

      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'b1010, 1'b0, 1'b0, 16'h1111);
      for (int i = 0; i < 2; i++) applyStimulus(1'b0, 4'b1010, 1'b1, 1'b0, 16'h1111);
      applyStimulus(1'b0, 4'b1010, 1'b0, 1'b0, 16'h1111);

      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 4'b1111, 1'b0, 1'b1, 16'h1111);

      applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1, 16'h1213);
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 4'b1111, 1'b0, 1'b1, 16'h1213);

      applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1, 16'h1111);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'b0101, 1'b0, 1'b1, 16'h1111);

      applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1, 16'h1114);
      for (int i = 0; i < 2; i++) applyStimulus(1'b0, 4'b0001, 1'b0, 1'b1, 16'h1114);
      applyStimulus(1'b1, 4'b0011, 1'b0, 1'b1, 16'h1114);
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 4'b0011, 1'b0, 1'b1, 16'h1114);

      applyStimulus(1'b0, 4'b1111, 1'b0, 1'b1, 16'hF0F2);
      for (int i = 0; i < 20; i++) applyStimulus(1'b0, 4'b1111, 1'b0, 1'b1, 16'hF0F2);

      md_r = 1'b1;
      wt_r = 16'h2311;
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 19) == 0) md_r = ~md_r;
         if ($urandom_range(0, 29) == 0) wt_r = 16'($urandom);
         applyStimulus($urandom_range(0, 59) == 0, 4'($urandom),
                       $urandom_range(0, 3) == 0, md_r, wt_r);
      end

      for (int i = 0; i < 2; i++) applyStimulus(1'b0, 4'b0000, 1'b0, md_r, wt_r);
      @(negedge clk);
      #1;
      compare("drain_fire4", 0, fire_q[0].size(), 0);
      compare("drain_fire3", 1, fire_q[1].size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
